// File: rtl/uart_rx_drain_ctrl.sv
// rtl/uart_rx_drain_ctrl.sv - RX FIFO prefetch/drain sequencer feeding the RXDATA register
// Pulls bytes from the FWFT RX FIFO into a small circular buffer, serves register
// reads from its head, tracks level/threshold/timeout status and runs a software flush.

module uart_rx_drain_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int LBUF_DEPTH = 4,
   parameter int TO_W       = 16
) (
   input  logic                          rd_clk,
   input  logic                          rd_rst,
   input  logic                          enable,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
   input  logic                          fifo_rd_empty,
   output logic                          fifo_rd_en,
   input  logic                          reg_rd_req,
   output logic [DATA_WIDTH-1:0]         reg_rd_data,
   output logic                          rx_avail,
   output logic [$clog2(LBUF_DEPTH):0]   level,
   input  logic [$clog2(LBUF_DEPTH):0]   threshold,
   input  logic [TO_W-1:0]               timeout_cycles,
   input  logic                          irq_clr,
   output logic                          thresh_flag,
   output logic                          timeout_flag,
   output logic                          underflow_err,
   output logic                          busy
);

   localparam int PW = $clog2(LBUF_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem_q [LBUF_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [LBUF_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
   logic                    thresh_flag_q, thresh_flag_d;
   logic                    timeout_flag_q, timeout_flag_d;
   logic                    underflow_q, underflow_d;

   logic                    rd_en;
   logic                    push;
   logic                    pop;
   logic                    to_hit;

   // State sequencing and FIFO pop request; a flush pulse overrides everything
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            rd_en = !fifo_rd_empty && (level_q < LW'(LBUF_DEPTH));
            if (!enable) state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            rd_en = !fifo_rd_empty;
            if (fifo_rd_empty) state_d = enable ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_FLUSH;
   end

   // Buffer push/pop, pointers, level, timeout counter and status flags
   always_comb begin
      mem_d          = mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      to_cnt_d       = to_cnt_q;
      timeout_flag_d = timeout_flag_q;

      // A byte taken on the flush cycle is discarded along with the buffer
      push = (state_q == ST_RUN) && rd_en && !flush;
      pop  = reg_rd_req && (level_q != '0) && (state_q != ST_FLUSH) && !flush;

      if (push) begin
         mem_d[wr_ptr_q] = fifo_rd_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end

      // Idle counter only runs while bytes sit untouched in the buffer
      if (push || pop || (level_q == '0) || (state_q == ST_FLUSH) || flush) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != '1) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      to_hit = (timeout_cycles != '0) && (level_q != '0) &&
               (to_cnt_q == (timeout_cycles - TO_W'(1)));
      if (to_hit) timeout_flag_d = 1'b1;
      if (irq_clr || pop || flush) timeout_flag_d = 1'b0;

      thresh_flag_d = (threshold != '0) && (level_d >= threshold);
      underflow_d   = underflow_q ||
                      (reg_rd_req && (level_q == '0) && (state_q != ST_FLUSH));
   end

   // State and datapath registers
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q        <= ST_IDLE;
         mem_q          <= '{default: '0};
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         to_cnt_q       <= '0;
         thresh_flag_q  <= 1'b0;
         timeout_flag_q <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_q          <= mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         to_cnt_q       <= to_cnt_d;
         thresh_flag_q  <= thresh_flag_d;
         timeout_flag_q <= timeout_flag_d;
         underflow_q    <= underflow_d;
      end
   end

   assign fifo_rd_en    = rd_en;
   assign reg_rd_data   = mem_q[rd_ptr_q];
   assign level         = level_q;
   assign rx_avail      = (level_q != '0);
   assign thresh_flag   = thresh_flag_q;
   assign timeout_flag  = timeout_flag_q;
   assign underflow_err = underflow_q;
   assign busy          = (state_q == ST_FLUSH);

endmodule
